// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage upstream of PC_control. It owns the PC, issues requests to
//   instruction memory (zero or more wait states) and registers the fetched instruction
//   with PC+2 into the IF/ID latch. It loads branch targets on redirect, holds on hazard
//   stalls through a one-entry skid buffer, and freezes after fetching HLT.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   imem_req/addr    fetch request and address; held stable until imem_valid
//   imem_data/valid  returned instruction and its one-cycle strobe
//   stall            hold PC and IF/ID
//   redirect/_pc     branch taken: load redirect_pc and flush IF/ID
//   if_id_instr      IF/ID instruction
//   if_id_pc_plus2   IF/ID PC+2
//   if_id_valid      IF/ID holds a live instruction
//   halted           HLT fetched, fetching stopped
//   dbg_state        current FSM state (FETCH=0, DRAIN=1, HOLD=2, HALTED=3)
//
// Handshake: a request is outstanding whenever imem_req=1. The address stays constant
// until a cycle with imem_valid=1, which completes it. The response may arrive in the
// same cycle that the request is first raised.
module fetch_stage #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus2,
  output logic               if_id_valid,
  output logic               halted,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [ADDR_W-1:0]  req_addr, req_addr_n;
  logic [INSTR_W-1:0] skid, skid_n;
  logic [INSTR_W-1:0] instr_n;
  logic [ADDR_W-1:0]  pcp2_n;
  logic               valid_n, halted_n;

  logic [ADDR_W-1:0]  pc_plus2;
  logic               take;
  logic [INSTR_W-1:0] take_data;

  assign pc_plus2 = pc + ADDR_W'(2);

  // Request is up in FETCH and DRAIN; reset forces it low even though state is FETCH.
  assign imem_req  = rst_n && ((state == FETCH) || (state == DRAIN));
  assign imem_addr = (state == DRAIN) ? req_addr : pc;
  assign dbg_state = state;

  // An instruction enters IF/ID either straight from memory (FETCH) or from the skid
  // buffer once the stall releases (HOLD).
  always_comb begin
    take      = 1'b0;
    take_data = imem_data;
    if (!redirect && !stall) begin
      if (state == FETCH && imem_valid) begin
        take = 1'b1;
      end else if (state == HOLD) begin
        take      = 1'b1;
        take_data = skid;
      end
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    skid_n     = skid;
    instr_n    = if_id_instr;
    pcp2_n     = if_id_pc_plus2;
    valid_n    = if_id_valid;
    halted_n   = halted;

    if (redirect) begin
      pc_n     = redirect_pc;
      instr_n  = '0;
      valid_n  = 1'b0;
      skid_n   = '0;
      halted_n = 1'b0;
      // The old request must be seen through before a new address can be presented.
      if ((state == FETCH || state == DRAIN) && !imem_valid) begin
        state_n = DRAIN;
        if (state == FETCH) req_addr_n = pc;
      end else begin
        state_n = FETCH;
      end
    end else if (take) begin
      instr_n = take_data;
      pcp2_n  = pc_plus2;
      valid_n = 1'b1;
      if (take_data[INSTR_W-1 -: 4] == HALT_OP) begin
        state_n  = HALTED;
        halted_n = 1'b1;
      end else begin
        pc_n    = pc_plus2;
        state_n = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_valid && stall) begin
            skid_n  = imem_data;
            state_n = HOLD;
          end
        end
        DRAIN: begin
          if (imem_valid) state_n = FETCH;  // stale response dropped
        end
        default: begin
          // HOLD under stall and HALTED keep everything.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      req_addr       <= RESET_PC;
      skid           <= '0;
      if_id_instr    <= '0;
      if_id_pc_plus2 <= '0;
      if_id_valid    <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      req_addr       <= req_addr_n;
      skid           <= skid_n;
      if_id_instr    <= instr_n;
      if_id_pc_plus2 <= pcp2_n;
      if_id_valid    <= valid_n;
      halted         <= halted_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .imem_valid     (imem_valid),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          n;       // number of consecutive cycles this vector is applied
    logic        st;
    logic        rd;
    logic [15:0] rpc;
    logic        v;
    logic [15:0] d;
    logic        req;     // checked just before the edge
    logic [15:0] addr;
    logic [15:0] instr;   // checked just after the edge
    logic [15:0] pcp2;
    logic        valid;
    logic        hlt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int n, input logic st, input logic rd, input logic [15:0] rpc,
                     input logic v, input logic [15:0] d, input logic req,
                     input logic [15:0] addr, input logic [15:0] instr,
                     input logic [15:0] pcp2, input logic valid, input logic hlt);
    vec_t t;
    t.n = n; t.st = st; t.rd = rd; t.rpc = rpc; t.v = v; t.d = d;
    t.req = req; t.addr = addr; t.instr = instr; t.pcp2 = pcp2;
    t.valid = valid; t.hlt = hlt;
    tbl.push_back(t);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},    {15'd0, imem_req},    16'd0);
    check({tag, "_addr"},   imem_addr,            16'h0000);
    check({tag, "_instr"},  if_id_instr,          16'h0000);
    check({tag, "_pcp2"},   if_id_pc_plus2,       16'h0000);
    check({tag, "_valid"},  {15'd0, if_id_valid}, 16'd0);
    check({tag, "_halted"}, {15'd0, halted},      16'd0);
    check({tag, "_state"},  {14'd0, dbg_state},   16'd0);
  endtask

  // driver: called at posedge+1; applies inputs, checks combinational outputs before
  // the next edge and registered outputs after it.
  task automatic apply(input vec_t t, input int idx);
    string s;
    stall       = t.st;
    redirect    = t.rd;
    redirect_pc = t.rpc;
    imem_valid  = t.v;
    imem_data   = t.d;
    #3;
    s = $sformatf("v%0d", idx);
    check({s, "_req"},  {15'd0, imem_req}, {15'd0, t.req});
    check({s, "_addr"}, imem_addr, t.addr);
    @(posedge clk);
    #1;
    check({s, "_instr"},  if_id_instr, t.instr);
    check({s, "_pcp2"},   if_id_pc_plus2, t.pcp2);
    check({s, "_valid"},  {15'd0, if_id_valid}, {15'd0, t.valid});
    check({s, "_halted"}, {15'd0, halted}, {15'd0, t.hlt});
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = 0; imem_valid = 0; imem_data = 0;

    //   n  st rd rpc      v  data     req addr     instr    pcp2     vld hlt
    // zero-wait memory, one instruction per cycle
    add(1, 0, 0, 16'h0000, 1, 16'h1234, 1, 16'h0000, 16'h1234, 16'h0002, 1, 0);
    add(1, 0, 0, 16'h0000, 1, 16'h5678, 1, 16'h0002, 16'h5678, 16'h0004, 1, 0);
    // stall with response -> skid, then HOLD for two more stall cycles, release
    add(1, 1, 0, 16'h0000, 1, 16'hABCD, 1, 16'h0004, 16'h5678, 16'h0004, 1, 0);
    add(2, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 16'h5678, 16'h0004, 1, 0);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 16'hABCD, 16'h0006, 1, 0);
    add(1, 0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0006, 16'h1111, 16'h0008, 1, 0);
    // stall with no response: nothing moves, request stays up
    add(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 16'h1111, 16'h0008, 1, 0);
    // 2-wait memory, redirect to 0040 in wait cycle, stale response drained
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 16'h1111, 16'h0008, 1, 0);
    add(1, 0, 1, 16'h0040, 0, 16'h0000, 1, 16'h0008, 16'h0000, 16'h0008, 0, 0);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 16'h0000, 16'h0008, 0, 0);
    add(1, 0, 0, 16'h0000, 1, 16'hDEAD, 1, 16'h0008, 16'h0000, 16'h0008, 0, 0);
    add(2, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 16'h0000, 16'h0008, 0, 0);
    add(1, 0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0040, 16'h2222, 16'h0042, 1, 0);
    // redirect + stall + response together: flush wins, skid stays empty
    add(1, 1, 1, 16'h0100, 1, 16'h3333, 1, 16'h0042, 16'h0000, 16'h0042, 0, 0);
    add(1, 0, 0, 16'h0000, 1, 16'h4444, 1, 16'h0100, 16'h4444, 16'h0102, 1, 0);
    // HLT at 000A, frozen 10 cycles (stray strobe ignored), redirect to 0020
    add(1, 0, 1, 16'h000A, 1, 16'h5555, 1, 16'h0102, 16'h0000, 16'h0102, 0, 0);
    add(1, 0, 0, 16'h0000, 1, 16'hF000, 1, 16'h000A, 16'hF000, 16'h000C, 1, 1);
    add(9, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h000A, 16'hF000, 16'h000C, 1, 1);
    add(1, 0, 0, 16'h0000, 1, 16'h7000, 0, 16'h000A, 16'hF000, 16'h000C, 1, 1);
    add(1, 0, 1, 16'h0020, 0, 16'h0000, 0, 16'h000A, 16'h0000, 16'h000C, 0, 0);
    add(1, 0, 0, 16'h0000, 1, 16'h6666, 1, 16'h0020, 16'h6666, 16'h0022, 1, 0);
    // PC wrap at FFFE
    add(1, 0, 1, 16'hFFFE, 1, 16'h7777, 1, 16'h0022, 16'h0000, 16'h0022, 0, 0);
    add(1, 0, 0, 16'h0000, 1, 16'h8888, 1, 16'hFFFE, 16'h8888, 16'h0000, 1, 0);
    add(1, 0, 0, 16'h0000, 1, 16'h9999, 1, 16'h0000, 16'h9999, 16'h0002, 1, 0);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 16'h9999, 16'h0002, 1, 0);

    // reset state while rst_n is low
    #7;
    check_reset_values("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].n; r++) apply(tbl[i], i);
    end

    // mid-wait asynchronous reset: pc=0002, request outstanding, no clock edge involved
    stall = 0; redirect = 0; imem_valid = 0;
    #2;
    check("pre_async_req", {15'd0, imem_req}, 16'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    // a late strobe for the old request while in reset is ignored
    imem_valid = 1'b1;
    imem_data  = 16'hBEEF;
    @(posedge clk);
    #1;
    check_reset_values("inrst");
    imem_valid = 1'b0;
    rst_n      = 1'b1;
    #3;
    check("post_rst_req",  {15'd0, imem_req}, 16'd1);
    check("post_rst_addr", imem_addr, 16'h0000);
    imem_valid = 1'b1;
    imem_data  = 16'h4321;
    @(posedge clk);
    #1;
    check("post_rst_instr", if_id_instr, 16'h4321);
    check("post_rst_pcp2",  if_id_pc_plus2, 16'h0002);
    check("post_rst_valid", {15'd0, if_id_valid}, 16'd1);
    imem_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
